// File: rtl/shift_add_mult_ctrl_if.sv
// Request/response bundle for the shift-and-add multiplier sequencer.
// master: requester drives start/a/b and watches ready/busy/done/product.
// slave:  sequencer side; drives the status flags and the registered product.
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 64
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiply, one partial product per clock on a single adder.
// Latency: done pulses WIDTH cycles after the accept edge; start-to-start minimum is WIDTH+2 cycles.
// Backpressure: start is only taken while ready (IDLE); the requester holds start until accepted.
// Ports: clk, reset (sync, active-high); bus (slave): start/a/b in, ready/busy/done/product out.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_mult_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic             last;

  // The only adder: carry-out lands in sum[WIDTH] and becomes the new acc MSB.
  assign sum  = {1'b0, acc} + {1'b0, (mq[0] ? mcand : {WIDTH{1'b0}})};
  assign last = (count == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from registered state only
  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      RUN:     bus.busy  = 1'b1;
      DONE:    bus.done  = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Datapath: {acc, mq} doubles as the product register and the multiplier shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          // Right shift of {cout, sum, mq}: sum LSB moves into the top of mq.
          acc   <= sum[WIDTH:1];
          mq    <= {sum[0], mq[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = {acc, mq};

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequencer that time-shares a single WIDTH-bit adder to compute an unsigned WIDTH x WIDTH -> 2*WIDTH product by shift-and-add, one partial product per clock. It serves multi-cycle MUL/UMULH-class operations in the ARM execute stage, where a full array multiplier is too large. It uses a start/ready/done handshake, and the result register holds its value until the next accepted start.

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH bits; legal range 2..64

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only when ready=1
a  input  WIDTH  multiplicand, unsigned; captured on the accept edge
b  input  WIDTH  multiplier, unsigned; captured on the accept edge
ready  output  1  high in IDLE only; start is accepted when start&ready
busy  output  1  high in RUN
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  registered result {acc, mq}

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State registers: state (IDLE/RUN/DONE), mcand[WIDTH], acc[WIDTH], mq[WIDTH], count[clog2(WIDTH)].
- Exactly one WIDTH-bit adder with carry-out: sum = acc + (mq[0] ? mcand : 0). No second adder is permitted.
- Reset (edge where reset=1, any state): state=IDLE, mcand=acc=mq=count=0, done=0. Reset has priority over all other inputs.
- Outputs after reset: ready=1, busy=0, done=0, product=0.
- ready, busy and done are decoded from state (registered state, no combinational path from start).
- IDLE + start=1: load mcand=a, mq=b, acc=0, count=0; go to RUN (this is the accept edge E0).
- IDLE + start=0: hold all registers; product is unchanged.
- RUN, each edge: {acc, mq} <= {cout, sum, mq[WIDTH-1:1]}, i.e. a right shift of {cout, sum, mq}; count++.
- RUN exit: on the edge where count==WIDTH-1 before the increment, go to DONE. RUN therefore lasts exactly WIDTH cycles (edges E1..E_WIDTH).
- DONE: done=1 for exactly one cycle (between E_WIDTH and E_WIDTH+1); product = a*b (mod 2^(2*WIDTH), never overflows). Next edge goes to IDLE unconditionally.
- Latency: done is high WIDTH cycles after the accept edge. Minimum start-to-start interval is WIDTH+2 cycles.
- start while RUN or DONE: ignored; no queuing. The requester must hold start until it sees ready.
- a and b may change freely after E0 with no effect on the in-flight result.
- product holds its value through DONE and IDLE until the next accept edge. From E0 onward it shows intermediate values and is undefined-for-use until done.
- Reset mid-RUN or in DONE: operation aborts, no done pulse, product=0 on the next cycle.
- Carry-out of the adder must feed the shift. This is required for a=b=2^WIDTH-1.

Test Plan:
- WIDTH=8; reset 2 cycles -> ready=1, busy=0, done=0, product=0.
- WIDTH=8; a=3, b=5, start 1 cycle -> busy=1 for 8 cycles, done=1 exactly 8 cycles after E0, product=15, ready=1 on the next cycle, product still 15 after 5 idle cycles.
- WIDTH=8; a=255, b=255 -> product=65025 (0xFE01), which checks carry-out propagation. Also a=0, b=200 -> 0 and a=128, b=2 -> 256.
- WIDTH=8; hold start=1 continuously with changing a/b -> new operations accepted only on IDLE edges (every 10 cycles). Each result matches the a/b sampled at its own accept edge, and mid-RUN changes have no effect.
- WIDTH=8; start a=7, b=9, assert reset at the 3rd RUN cycle -> next cycle ready=1, product=0, no done pulse. A fresh start a=7, b=9 then yields 63.
- WIDTH=64; a=2^64-1, b=2^64-1 -> product=2^128-2^65+1 after 64 cycles. Also run 1000 random pairs checked against a reference a*b.
